interval_timer_mc: RTL
======================

# interval_timer_mc

Parametrised multi-channel start/stop interval timer for the link test firmware. Each channel measures the number of `clk` cycles between a start strobe and a stop strobe, exposes the live count, latches the final interval into a capture register and pulses a per-channel valid flag. It is the multi-channel, width-generic successor of the single-channel 8-bit start/stop cycle timer. It sits between the link event decoders, which supply the start and stop strobes, and the register/readout logic.

## Interface
- `WIDTH`, default 16: counter and capture width in bits, minimum 2.
- `NCH`, default 4: number of independent channels, minimum 1.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is released synchronously by the upstream reset bridge.
- `clear`  in  1  synchronous global clear, active-high.
- `start`  in  NCH  per-channel start strobe, sampled every edge.
- `stop`  in  NCH  per-channel stop strobe, sampled every edge.
- `running`  out  NCH  channel is in RUN.
- `count`  out  NCH*WIDTH  live counters; channel i occupies bits [i*WIDTH +: WIDTH].
- `capture`  out  NCH*WIDTH  last completed interval per channel, using the same packing as `count`.
- `capture_valid`  out  NCH  one-cycle pulse when `capture[i]` updates.
- `overflow`  out  NCH  sticky overflow flag per channel.

## Operation
- Each channel runs an identical, independent two-state FSM: IDLE and RUN.
- **IDLE**
  - `start`=1 and `stop`=0: go to RUN; `count` loads 0; `overflow` clears.
  - `start`=1 and `stop`=1: stop wins; stay in IDLE with no change.
  - Otherwise hold. `count` and `capture` keep their values.
- **RUN**
  - Every edge: `count` <= `count`+1, subject to the overflow rule below.
  - `stop`=1, regardless of `start`: go to IDLE; `capture` <= the incremented count value; `capture_valid` pulses for 1 cycle.
  - `start`=1 and `stop`=0: ignored; no restart, counting continues.
- **Overflow:** an increment from all-ones is an overflow event. The rule is set by the Configuration section. `overflow` stays set until the next start or `clear`.
- **clear:** overrides start/stop on all channels. All channels go to IDLE; `count`, `capture`, `overflow` and `capture_valid` all go to 0.
- **reset_n low:** asynchronous; same effect as `clear`. Reset mid-interval discards the measurement and produces no `capture_valid`.
- Channels share nothing except `clk`, `reset_n` and `clear`.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `start` sampled at edge E0: after E0, `running`=1 and `count`=0. After edge Ek, `count`=k.
- `stop` sampled at edge Ek (k>=1): after Ek, `count`=`capture`=k, `running`=0 and `capture_valid`=1. After Ek+1, `capture_valid`=0.
- Latency from strobe to outputs: 1 cycle.
- Back-to-back operation:
  - `start` may be asserted on the edge after the stop edge; the new interval then begins immediately.
  - Minimum measurable interval is 1.
- Strobes are level-sampled. Holding `start` high keeps re-arming from IDLE but has no effect while in RUN.

## Configuration
- `INTERVAL_TIMER_SATURATE_EN` defined:
  - An overflow holds `count` at all-ones and sets `overflow`.
  - A later stop captures all-ones.
- Not defined:
  - An overflow wraps `count` to 0 and sets `overflow`.
  - The capture holds the value modulo 2^WIDTH; software combines it with `overflow`.

## Test plan
- Reset, WIDTH=16, NCH=4: hold `reset_n` low mid-run on ch0 -> all outputs 0, no `capture_valid`; after release ch0 is IDLE.
- Ch1: `start` at E0, `stop` at E5 -> `capture[1]`=5 and `capture_valid[1]` high for exactly one cycle after E5; other channels unchanged.
- Simultaneous events:
  - Ch2 `start`+`stop` together in IDLE -> stays IDLE, `count` unchanged.
  - Ch2 in RUN with `start` re-pulsed at E3 and `stop` at E7 -> `capture[2]`=7 (no restart).
- Overflow, WIDTH=4:
  - Run 18 cycles with the macro defined -> `capture`=15 and `overflow`=1.
  - Without the macro -> `capture`=2 and `overflow`=1.
  - The next start clears `overflow`.
- `clear` while ch0 and ch3 are in RUN and ch1 has `capture`=5 -> next cycle all `count`, `capture` and `overflow` are 0 and all channels IDLE; `start` on the following edge begins a normal interval.
- Back-to-back on ch0: `stop` at E4, `start` at E5, `stop` at E8 -> two `capture_valid` pulses with values 4 then 3.

Source files
------------

// File: rtl/interval_timer_mc.sv
// -----------------------------------------------------------------------------
// interval_timer_mc
// Multi-channel start/stop interval timer. Each channel counts clk cycles
// between a start strobe and a stop strobe, exposes the live count, latches
// the finished interval into a capture register and pulses capture_valid.
//
// Optional build macro: INTERVAL_TIMER_SATURATE_EN
//   defined   -> an overflow holds the counter at all-ones
//   undefined -> an overflow wraps the counter to zero
//   In both cases the sticky overflow flag is set.
//
// Ports
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   clear          synchronous global clear, active-high
//   start[NCH]     per-channel start strobe (level sampled)
//   stop[NCH]      per-channel stop strobe (level sampled)
//   running[NCH]   channel is in RUN
//   count          live counters, channel i at [i*WIDTH +: WIDTH]
//   capture        last completed interval, same packing as count
//   capture_valid  one-cycle pulse when a channel's capture updates
//   overflow       sticky per-channel overflow flag
// -----------------------------------------------------------------------------
module interval_timer_mc #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    output logic [NCH-1:0]       running,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH*WIDTH-1:0] capture,
    output logic [NCH-1:0]       capture_valid,
    output logic [NCH-1:0]       overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Next counter value; the MSB flags an increment out of all-ones.
    function automatic logic [WIDTH:0] next_count(input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        if (&cur) begin
`ifdef INTERVAL_TIMER_SATURATE_EN
            next_count = {1'b1, {WIDTH{1'b1}}};
`else
            next_count = {1'b1, {WIDTH{1'b0}}};
`endif
        end else begin
            next_count = {1'b0, cur + one};
        end
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_e           state_q,   state_d;
        logic [WIDTH-1:0] count_q,   count_d;
        logic [WIDTH-1:0] capture_q, capture_d;
        logic             valid_q,   valid_d;
        logic             ovf_q,     ovf_d;
        logic [WIDTH:0]   nxt_s;

        // Increment candidate used while running.
        always_comb begin
            nxt_s = next_count(count_q);
        end

        // Per-channel next-state: clear dominates, then the IDLE/RUN rules.
        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            capture_d = capture_q;
            valid_d   = 1'b0;
            ovf_d     = ovf_q;
            if (clear) begin
                state_d   = ST_IDLE;
                count_d   = {WIDTH{1'b0}};
                capture_d = {WIDTH{1'b0}};
                ovf_d     = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // A simultaneous stop suppresses the start.
                        if (start[g] && !stop[g]) begin
                            state_d = ST_RUN;
                            count_d = {WIDTH{1'b0}};
                            ovf_d   = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        count_d = nxt_s[WIDTH-1:0];
                        if (nxt_s[WIDTH]) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_q;
                        end
                        // Capture the incremented value so the interval
                        // includes the stop edge itself.
                        if (stop[g]) begin
                            state_d   = ST_IDLE;
                            capture_d = nxt_s[WIDTH-1:0];
                            valid_d   = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        // Channel state registers with asynchronous reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= ST_IDLE;
                count_q   <= {WIDTH{1'b0}};
                capture_q <= {WIDTH{1'b0}};
                valid_q   <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                capture_q <= capture_d;
                valid_q   <= valid_d;
                ovf_q     <= ovf_d;
            end
        end

        assign running[g]                  = (state_q == ST_RUN);
        assign count[g*WIDTH +: WIDTH]     = count_q;
        assign capture[g*WIDTH +: WIDTH]   = capture_q;
        assign capture_valid[g]            = valid_q;
        assign overflow[g]                 = ovf_q;
    end

endmodule
